// File: rtl/psram_qspi_target.sv
// Device-side QSPI PSRAM responder: oversamples ncs/sck/di, decodes command/address/wait/data
// and bridges the bus to a 32-bit word memory port.
module psram_qspi_target #(
  parameter int unsigned AW      = 12,
  parameter logic [7:0]  OP_WR   = 8'h02,
  parameter logic [7:0]  OP_WR_Q = 8'h38,
  parameter logic [7:0]  OP_RD   = 8'h03,
  parameter logic [7:0]  OP_RD_F = 8'hEB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ncs,
  input  logic          sck,
  input  logic [3:0]    di,
  output logic [3:0]    dout,
  output logic [3:0]    do_en,
  input  logic [1:0]    cmd_width,
  input  logic [1:0]    addr_width,
  input  logic [1:0]    data_width,
  input  logic [3:0]    wait_cyc,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WAIT, S_WDATA, S_RDATA, S_SKIP
  } state_t;

  logic [2:0]    ncs_q, sck_q;
  logic [3:0]    di_s1_q, di_s2_q;
  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [1:0]    width_q, width_d;
  logic [7:0]    op_q, op_d;
  logic [31:0]   sr_q, sr_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
  logic          rd_pend_q, rd_pend_d, pref_q, pref_d;
  logic [3:0]    dout_q, dout_d, do_en_q, do_en_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic          ncs_fall, ncs_rise, sck_rise, sck_fall, last;
  logic [5:0]    n;
  logic [31:0]   sr_in, src, src_shift;
  logic [3:0]    grp_out, en_pat;

  assign ncs_fall = ~ncs_q[1] & ncs_q[2];
  assign ncs_rise = ncs_q[1] & ~ncs_q[2];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign last     = (cnt_q == n);
  // A word landing on the same clk as a falling edge is shifted out directly.
  assign src      = rd_pend_q ? mem_rdata : sr_q;

  always_comb begin
    case (width_q)
      2'd1: begin
        n = 6'd2; sr_in = {sr_q[29:0], di_s2_q[1:0]};
        grp_out = {2'b00, src[31:30]}; src_shift = {src[29:0], 2'b00}; en_pat = 4'b0011;
      end
      2'd2: begin
        n = 6'd4; sr_in = {sr_q[27:0], di_s2_q};
        grp_out = src[31:28]; src_shift = {src[27:0], 4'b0000}; en_pat = 4'b1111;
      end
      default: begin
        n = 6'd1; sr_in = {sr_q[30:0], di_s2_q[0]};
        grp_out = {2'b00, src[31], 1'b0}; src_shift = {src[30:0], 1'b0}; en_pat = 4'b0010;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    op_d        = op_q;
    sr_d        = sr_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    rd_pend_d   = mem_rd_q;
    pref_d      = 1'b0;
    dout_d      = dout_q;
    do_en_d     = do_en_q;
    busy_d      = ~ncs_q[1];
    done_d      = ncs_rise;
    if (mem_wr_q) mem_addr_d = mem_addr_q + 1'b1;

    case (state_q)
      S_IDLE: if (ncs_fall) begin
        state_d = S_CMD; cnt_d = 6'd8; width_d = cmd_width; sr_d = '0;
      end
      S_CMD: if (sck_rise) begin
        sr_d = sr_in;
        if (last) begin
          op_d = sr_in[7:0];
          if (sr_in[7:0] == OP_WR || sr_in[7:0] == OP_WR_Q ||
              sr_in[7:0] == OP_RD || sr_in[7:0] == OP_RD_F) begin
            state_d = S_ADDR; cnt_d = 6'd24; width_d = addr_width;
          end else begin
            state_d = S_SKIP;
          end
        end else begin
          cnt_d = cnt_q - n;
        end
      end
      S_ADDR: if (sck_rise) begin
        sr_d = sr_in;
        if (last) begin
          mem_addr_d = sr_in[AW-1:0];
          cnt_d      = 6'd32;
          width_d    = data_width;
          if (op_q == OP_WR || op_q == OP_WR_Q) begin
            state_d = S_WDATA;
          end else if (op_q == OP_RD_F && wait_cyc != 4'd0) begin
            state_d = S_WAIT; wait_cnt_d = wait_cyc;
          end else begin
            state_d = S_RDATA; mem_rd_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - n;
        end
      end
      S_WAIT: if (sck_rise) begin
        if (wait_cnt_q == 4'd1) begin
          state_d = S_RDATA; mem_rd_d = 1'b1; cnt_d = 6'd32; width_d = data_width;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_WDATA: if (sck_rise) begin
        sr_d = sr_in;
        if (last) begin
          mem_wr_d = 1'b1; mem_wdata_d = sr_in; cnt_d = 6'd32;
        end else begin
          cnt_d = cnt_q - n;
        end
      end
      S_RDATA: begin
        if (sck_fall) begin
          dout_d  = grp_out;
          do_en_d = en_pat;
          sr_d    = src_shift;
          if (last) begin
            cnt_d = 6'd32; mem_addr_d = mem_addr_q + 1'b1; pref_d = 1'b1;
          end else begin
            cnt_d = cnt_q - n;
          end
        end else if (rd_pend_q) begin
          sr_d = mem_rdata;
        end
        if (pref_q) mem_rd_d = 1'b1;
      end
      S_SKIP: ;
      default: state_d = S_IDLE;
    endcase

    // ncs release wins over everything except a word completed on the same sample.
    if (ncs_rise) begin
      state_d   = S_IDLE;
      do_en_d   = '0;
      dout_d    = '0;
      pref_d    = 1'b0;
      mem_rd_d  = 1'b0;
      rd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_q       <= '1;
      sck_q       <= '0;
      di_s1_q     <= '0;
      di_s2_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      op_q        <= '0;
      sr_q        <= '0;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      pref_q      <= 1'b0;
      dout_q      <= '0;
      do_en_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ncs_q       <= {ncs_q[1:0], ncs};
      sck_q       <= {sck_q[1:0], sck};
      di_s1_q     <= di;
      di_s2_q     <= di_s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      op_q        <= op_d;
      sr_q        <= sr_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      rd_pend_q   <= rd_pend_d;
      pref_q      <= pref_d;
      dout_q      <= dout_d;
      do_en_q     <= do_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dout      = dout_q;
  assign do_en     = do_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_psram_qspi_target.sv
// Directed bench for psram_qspi_target: acts as the QSPI initiator and as the word memory.
module tb_psram_qspi_target;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ncs, sck;
  logic [3:0]  di, wait_cyc;
  logic [1:0]  cmd_width, addr_width, data_width;
  logic [3:0]  dout, do_en, dout4, do_en4;
  logic        mem_wr, mem_rd, busy, done, mem_wr4, mem_rd4, busy4, done4;
  logic [11:0] mem_addr;
  logic [3:0]  mem_addr4;
  logic [31:0] mem_wdata, mem_wdata4, mem_rdata;

  psram_qspi_target #(.AW(12)) u_dut (
    .clk(clk), .rst(rst), .ncs(ncs), .sck(sck), .di(di), .dout(dout), .do_en(do_en),
    .cmd_width(cmd_width), .addr_width(addr_width), .data_width(data_width), .wait_cyc(wait_cyc),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done));

  psram_qspi_target #(.AW(4)) u_dut4 (
    .clk(clk), .rst(rst), .ncs(ncs), .sck(sck), .di(di), .dout(dout4), .do_en(do_en4),
    .cmd_width(cmd_width), .addr_width(addr_width), .data_width(data_width), .wait_cyc(wait_cyc),
    .mem_wr(mem_wr4), .mem_rd(mem_rd4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(32'h0), .busy(busy4), .done(done4));

  function automatic logic [31:0] rom(input logic [11:0] a);
    case (a)
      12'h000: rom = 32'hCAFEF00D;
      12'h020: rom = 32'hDEADBEEF;
      12'h021: rom = 32'h01234567;
      default: rom = {20'h5A5A5, a};
    endcase
  endfunction

  // Memory model and event logs (monotonic counters; tests take deltas).
  int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, en_cnt = 0, wr4_cnt = 0, done4_cnt = 0;
  logic [11:0] wr_addr_log [16];
  logic [31:0] wr_data_log [16];
  logic [11:0] rd_addr_log [16];
  logic [3:0]  wr4_addr_log [16];
  logic [31:0] wr4_data_log [16];

  always @(posedge clk) begin
    if (mem_wr) begin
      wr_addr_log[wr_cnt[3:0]] <= mem_addr;
      wr_data_log[wr_cnt[3:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd) begin
      rd_addr_log[rd_cnt[3:0]] <= mem_addr;
      mem_rdata <= rom(mem_addr);
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_wr4) begin
      wr4_addr_log[wr4_cnt[3:0]] <= mem_addr4;
      wr4_data_log[wr4_cnt[3:0]] <= mem_wdata4;
      wr4_cnt <= wr4_cnt + 1;
    end
    if (done)        done_cnt  <= done_cnt + 1;
    if (done4)       done4_cnt <= done4_cnt + 1;
    if (do_en != '0) en_cnt    <= en_cnt + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] d, output logic [3:0] q, output logic [3:0] qen);
    di = d;
    @(negedge clk);
    q   = dout;
    qen = do_en;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] val, input int nbits, input int n);
    logic [31:0] t;
    logic [3:0]  d, q, qe;
    for (int i = nbits - n; i >= 0; i -= n) begin
      t = val >> i;
      case (n)
        1:       d = {3'b000, t[0]};
        2:       d = {2'b00, t[1:0]};
        default: d = t[3:0];
      endcase
      pulse(d, q, qe);
    end
  endtask

  task automatic recv_word(input int n, output logic [31:0] word, output logic [3:0] en);
    logic [3:0] q, qe;
    word = '0;
    for (int i = 0; i < 32 / n; i++) begin
      pulse(4'h0, q, qe);
      if (i == 0) en = qe;
      case (n)
        1:       word = {word[30:0], q[1]};
        2:       word = {word[29:0], q[1:0]};
        default: word = {word[27:0], q};
      endcase
    end
  endtask

  task automatic cs_start();
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_stop();
    ncs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] cw, input logic [1:0] aw, input logic [1:0] dw,
                         input logic [3:0] wc);
    cmd_width = cw; addr_width = aw; data_width = dw; wait_cyc = wc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0, e0, w40, d40;
    logic [31:0] word0, word1;
    logic [3:0]  en0, en1, q, qe;

    rst = 1'b1; ncs = 1'b1; sck = 1'b0; di = '0;
    set_cfg(2'd0, 2'd0, 2'd0, 4'd0);
    repeat (4) @(negedge clk);
    check("reset_outputs", {dout, do_en, mem_wr, mem_rd, mem_addr, mem_wdata, busy, done}, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1-line write of two words at 0x010
    w0 = wr_cnt; d0 = done_cnt;
    set_cfg(2'd0, 2'd0, 2'd0, 4'd0);
    cs_start();
    check("wr1_busy", busy, 1'b1);
    send_bits(32'h02, 8, 1);
    send_bits(32'h000010, 24, 1);
    send_bits(32'h12345678, 32, 1);
    send_bits(32'h9ABCDEF0, 32, 1);
    cs_stop();
    check("wr1_count", wr_cnt - w0, 2);
    check("wr1_addr0", wr_addr_log[w0[3:0]], 12'h010);
    check("wr1_data0", wr_data_log[w0[3:0]], 32'h12345678);
    check("wr1_addr1", wr_addr_log[4'(w0 + 1)], 12'h011);
    check("wr1_data1", wr_data_log[4'(w0 + 1)], 32'h9ABCDEF0);
    check("wr1_done", done_cnt - d0, 1);

    // Quad fast read with 6 dummy cycles at 0x020
    r0 = rd_cnt; d0 = done_cnt; e0 = en_cnt;
    set_cfg(2'd0, 2'd2, 2'd2, 4'd6);
    cs_start();
    send_bits(32'hEB, 8, 1);
    send_bits(32'h000020, 24, 4);
    for (int i = 0; i < 5; i++) pulse(4'h0, q, qe);
    check("qrd_no_rd_before_6th", rd_cnt - r0, 0);
    check("qrd_do_en_idle", en_cnt - e0, 0);
    pulse(4'h0, q, qe);
    check("qrd_rd_after_6th", rd_cnt - r0, 1);
    check("qrd_rd_addr0", rd_addr_log[r0[3:0]], 12'h020);
    recv_word(4, word0, en0);
    recv_word(4, word1, en1);
    check("qrd_do_en", en0, 4'b1111);
    check("qrd_word0", word0, 32'hDEADBEEF);
    check("qrd_word1", word1, 32'h01234567);
    check("qrd_rd_addr1", rd_addr_log[4'(r0 + 1)], 12'h021);
    cs_stop();
    check("qrd_do_en_off", do_en, 4'b0000);
    check("qrd_done", done_cnt - d0, 1);

    // Address wrap on the AW=4 instance
    w40 = wr4_cnt; d40 = done4_cnt;
    set_cfg(2'd1, 2'd2, 2'd2, 4'd0);
    cs_start();
    send_bits(32'h02, 8, 2);
    send_bits(32'h00000F, 24, 4);
    send_bits(32'hA5A50001, 32, 4);
    send_bits(32'h5A5A0002, 32, 4);
    cs_stop();
    check("wrap_count", wr4_cnt - w40, 2);
    check("wrap_addr0", wr4_addr_log[w40[3:0]], 4'hF);
    check("wrap_data0", wr4_data_log[w40[3:0]], 32'hA5A50001);
    check("wrap_addr1", wr4_addr_log[4'(w40 + 1)], 4'h0);
    check("wrap_data1", wr4_data_log[4'(w40 + 1)], 32'h5A5A0002);
    check("wrap_done", done4_cnt - d40, 1);

    // Abort after 20 data bits
    w0 = wr_cnt; d0 = done_cnt;
    set_cfg(2'd0, 2'd0, 2'd0, 4'd0);
    cs_start();
    send_bits(32'h02, 8, 1);
    send_bits(32'h000030, 24, 1);
    send_bits(32'h000ABCDE, 20, 1);
    cs_stop();
    check("abort_no_wr", wr_cnt - w0, 0);
    check("abort_done", done_cnt - d0, 1);
    check("abort_do_en", do_en, 4'b0000);
    check("abort_busy", busy, 1'b0);

    // Unknown opcode followed by 40 clocks
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = en_cnt;
    cs_start();
    send_bits(32'h9F, 8, 1);
    for (int i = 0; i < 40; i++) pulse(4'(i), q, qe);
    cs_stop();
    check("unk_no_wr", wr_cnt - w0, 0);
    check("unk_no_rd", rd_cnt - r0, 0);
    check("unk_do_en", en_cnt - e0, 0);
    check("unk_done", done_cnt - d0, 1);

    // Reset mid quad read, then a plain 1-line read of address 0
    set_cfg(2'd0, 2'd2, 2'd2, 4'd6);
    cs_start();
    send_bits(32'hEB, 8, 1);
    send_bits(32'h000020, 24, 4);
    for (int i = 0; i < 6 + 3; i++) pulse(4'h0, q, qe);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {dout, do_en, mem_wr, mem_rd, mem_addr, mem_wdata, busy, done}, '0);
    rst = 1'b0;
    cs_stop();
    r0 = rd_cnt;
    set_cfg(2'd0, 2'd0, 2'd0, 4'd0);
    cs_start();
    send_bits(32'h03, 8, 1);
    send_bits(32'h000000, 24, 1);
    recv_word(1, word0, en0);
    cs_stop();
    check("rd03_rd_addr", rd_addr_log[r0[3:0]], 12'h000);
    check("rd03_word", word0, 32'hCAFEF00D);
    check("rd03_do_en", en0, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
